// File: rtl/thoth_pkg.sv
// Shared write-back widths and the request payload used by the execute and load stages.
package thoth_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned NREGS     = 2 ** REG_IDX_W;

   typedef struct packed {
      logic [REG_IDX_W-1:0] idx;
      logic [XLEN-1:0]      data;
   } wb_req_t;

endpackage : thoth_pkg

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a write-back requester, with ready logic and x0 filter.
module wb_hold_slot #(
   parameter int unsigned XLEN      = thoth_pkg::XLEN,
   parameter int unsigned REG_IDX_W = thoth_pkg::REG_IDX_W
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 valid_i,
   input  logic [REG_IDX_W-1:0] idx_i,
   input  logic [XLEN-1:0]      data_i,
   input  logic                 grant_i,
   output logic                 ready_c,
   output logic                 fill_c,
   output logic                 full_o,
   output logic [REG_IDX_W-1:0] idx_o,
   output logic [XLEN-1:0]      data_o
);

   logic                 full_q;
   logic [REG_IDX_W-1:0] idx_q;
   logic [XLEN-1:0]      data_q;

   // Writes to x0 are accepted but never occupy the entry.
   always_comb begin
      ready_c = !full_q || grant_i;
      fill_c  = valid_i && ready_c && (idx_i != '0);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         full_q <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
      end else if (fill_c) begin
         full_q <= 1'b1;
         idx_q  <= idx_i;
         data_q <= data_i;
      end else if (grant_i) begin
         full_q <= 1'b0;
      end
   end

   assign full_o = full_q;
   assign idx_o  = idx_q;
   assign data_o = data_q;

endmodule : wb_hold_slot

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first arbiter between execute and load write-backs onto the single regfile write port.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN      = thoth_pkg::XLEN,
   parameter int unsigned REG_IDX_W = thoth_pkg::REG_IDX_W,
   localparam int unsigned NREGS    = 2 ** REG_IDX_W
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
   input  logic [XLEN-1:0]      ex_rd_data_i,
   input  logic                 ld_valid_i,
   output logic                 ld_ready_o,
   input  logic [REG_IDX_W-1:0] ld_rd_idx_i,
   input  logic [XLEN-1:0]      ld_rd_data_i,
   output logic                 rf_wen_o,
   output logic [REG_IDX_W-1:0] rf_rd_idx_o,
   output logic [XLEN-1:0]      rf_rd_data_o,
   output logic [NREGS-1:0]     pend_mask_o
);

   logic                 ex_full, ld_full;
   logic                 ex_fill_c, ld_fill_c;
   logic                 ex_grant_c, ld_grant_c;
   logic [REG_IDX_W-1:0] ex_idx, ld_idx;
   logic [XLEN-1:0]      ex_data, ld_data;
   logic                 age_q;
   logic                 wen_q;
   logic [REG_IDX_W-1:0] out_idx_q;
   logic [XLEN-1:0]      out_data_q;
   logic [NREGS-1:0]     pend_mask_c;

   wb_hold_slot #(
      .XLEN      (XLEN),
      .REG_IDX_W (REG_IDX_W)
   ) u_ex_slot (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (ex_valid_i),
      .idx_i    (ex_rd_idx_i),
      .data_i   (ex_rd_data_i),
      .grant_i  (ex_grant_c),
      .ready_c  (ex_ready_o),
      .fill_c   (ex_fill_c),
      .full_o   (ex_full),
      .idx_o    (ex_idx),
      .data_o   (ex_data)
   );

   wb_hold_slot #(
      .XLEN      (XLEN),
      .REG_IDX_W (REG_IDX_W)
   ) u_ld_slot (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (ld_valid_i),
      .idx_i    (ld_rd_idx_i),
      .data_i   (ld_rd_data_i),
      .grant_i  (ld_grant_c),
      .ready_c  (ld_ready_o),
      .fill_c   (ld_fill_c),
      .full_o   (ld_full),
      .idx_o    (ld_idx),
      .data_o   (ld_data)
   );

   // age_q set means the held ex entry predates the held ld entry.
   always_comb begin
      ex_grant_c = ex_full && (!ld_full || age_q);
      ld_grant_c = ld_full && (!ex_full || !age_q);
   end

   // A fresh entry is younger than anything still held; same-edge fills leave ld older.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         age_q <= 1'b0;
      end else if (ex_fill_c) begin
         age_q <= 1'b0;
      end else if (ld_fill_c) begin
         age_q <= ex_full && !ex_grant_c;
      end
   end

   // Output register feeding the regfile write port; index/data hold when idle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wen_q      <= 1'b0;
         out_idx_q  <= '0;
         out_data_q <= '0;
      end else if (ld_grant_c) begin
         wen_q      <= 1'b1;
         out_idx_q  <= ld_idx;
         out_data_q <= ld_data;
      end else if (ex_grant_c) begin
         wen_q      <= 1'b1;
         out_idx_q  <= ex_idx;
         out_data_q <= ex_data;
      end else begin
         wen_q      <= 1'b0;
      end
   end

   always_comb begin
      pend_mask_c = '0;
      if (ex_full) pend_mask_c = pend_mask_c | (NREGS'(1) << ex_idx);
      if (ld_full) pend_mask_c = pend_mask_c | (NREGS'(1) << ld_idx);
      if (wen_q)   pend_mask_c = pend_mask_c | (NREGS'(1) << out_idx_q);
      pend_mask_c[0] = 1'b0;
   end

   assign rf_wen_o     = wen_q;
   assign rf_rd_idx_o  = out_idx_q;
   assign rf_rd_data_o = out_data_q;
   assign pend_mask_o  = pend_mask_c;

endmodule : regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the single write port of `regfile`. It accepts register writes from two requesters, the execute stage (`ex`) and the load unit (`ld`), over valid/ready handshakes. Each requester has a one-entry holding register. Held writes are serialised oldest-first onto registered `wen_i`/`rd_idx_i`/`rd_data_i` of `regfile`. A pending-write mask is exported so the hazard logic can stall readers of registers with writes in flight.

## Interface
- `XLEN`, 32, data width
- `REG_IDX_W`, 5, register index width; `NREGS = 2**REG_IDX_W`

Ports:
- `clk_i`  in  1  clock, rising edge
- `reset_ni`  in  1  asynchronous, active-low reset
- `ex_valid_i`  in  1  execute write request
- `ex_ready_o`  out  1  execute request accepted this cycle when high with valid
- `ex_rd_idx_i`  in  REG_IDX_W  execute destination
- `ex_rd_data_i`  in  XLEN  execute result
- `ld_valid_i`, `ld_ready_o`, `ld_rd_idx_i`, `ld_rd_data_i`  same as `ex_*`, for the load unit
- `rf_wen_o`  out  1  to `regfile.wen_i`, registered
- `rf_rd_idx_o`  out  REG_IDX_W  to `regfile.rd_idx_i`, registered
- `rf_rd_data_o`  out  XLEN  to `regfile.rd_data_i`, registered
- `pend_mask_o`  out  NREGS  bit r set while a write to r is held or on the output register

## Operation
- Per requester: holding register {`full`, `idx`, `data`} and an `age` bit.
- The `age` bit marks an `ex` entry older than the `ld` entry.
- Handshake: `x_ready_o = !x_full | x_grant`. This path is combinational from the grant, with no dependency on `x_valid_i`.
- Transfer: a transfer occurs when `x_valid_i & x_ready_o` at a rising edge.
- x0 filter: a transfer with `rd_idx == 0` is consumed and discarded. It never fills the holding register, never raises `rf_wen_o`, and never sets a mask bit.
- Arbitration, evaluated each cycle over the full entries:
  - Only one entry full: that entry wins.
  - Both entries full: the older entry wins.
  - Both entries filled on the same edge: `ld` wins. Upstream guarantees that a load presented together with an ex write is older in program order.
- Grant effect: the winner's entry is loaded into the output register at the next edge with `rf_wen_o=1`, and the winner's `full` is cleared. A new transfer on the same edge refills the entry. A newly filled entry is always younger than an entry already held.
- No winner: `rf_wen_o=0` at the next edge. `rf_rd_idx_o` and `rf_rd_data_o` hold their last values.
- Mask: `pend_mask_o` is the OR of the decoded `idx` of each full entry and `rf_rd_idx_o` when `rf_wen_o`. It is combinational from state only. Bit 0 is always 0.

## Timing
- Reset values: all `full=0`, `age=0`, `rf_wen_o=0`, `rf_rd_idx_o=0`, `rf_rd_data_o=0`, `pend_mask_o=0`. The ready outputs are 1.
- Reset mid-operation: held and in-flight writes are dropped immediately with no partial write.
- Latency:
  - Transfer at edge N.
  - Entry granted during cycle N..N+1.
  - `rf_wen_o` is high from edge N+1 to edge N+2.
  - `regfile` commits at edge N+2.
- Extra wait: one cycle per older competing entry.
- Throughput: one write per cycle sustained. With both requesters streaming, each sees `ready` about 50% of the time.
- Same-rd case: writes to the same `rd` commit in arbitration order. No merging and no dropping.

## Structure
- Package `thoth_pkg` holds the `XLEN`/`REG_IDX_W` defaults and the `wb_req_t` {idx, data} typedef. The typedef is shared with the execute and load stages.
- A natural sub-module is `wb_hold_slot`. It contains one holding register plus the ready logic and the x0 filter, and is instanced twice. The top level holds the age bit, arbitration, the output register and the mask.

## Test plan
- Single ex write: ex x3=0x1337, followed through `regfile` -> `rf_wen_o` is high one cycle after the transfer, and rs1 read of x3 returns 0x1337 at edge N+2. `pend_mask_o[3]` is 1 for 2 cycles, then 0.
- Simultaneous: ld x5=0xAAAA and ex x5=0xBBBB on the same edge -> ld is written first, ex next cycle, and x5 finally reads 0xBBBB. `ex_ready_o=0` for exactly one cycle.
- Age order: ex x7=1 at edge N, ld x8=2 at edge N+1 while ex is held by prior traffic -> x7 commits before x8.
- x0 filter: ex x0=0xDEAD -> `ex_ready_o=1`, `rf_wen_o` stays 0, `pend_mask_o=0`, and x0 reads 0.
- Back-pressure: both valid for 10 cycles with distinct rd -> 10 commits in 10 consecutive cycles after a 1-cycle fill, alternating ld/ex, with no loss.
- Async reset asserted with both entries full -> outputs and mask read 0 before the next edge. After release, no stale write occurs.
